// File: rtl/multi_sum_serializer_if.sv
// Load/stream bundle between the lane-sum snapshot port and the serialized output stream.
// "master" is the serializer side, "slave" the producer/consumer environment.
interface multi_sum_serializer_if #(
  parameter int unsigned N   = 12,
  parameter int unsigned CNT = 8
);
  localparam int unsigned LW = (CNT > 1) ? $clog2(CNT) : 1;

  logic [CNT*(N+1)-1:0] sum_flat;
  logic                 load_valid;
  logic                 load_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [N:0]           out_data;
  logic [LW-1:0]        out_lane;
  logic                 out_last;

  modport master (
    input  sum_flat, load_valid, out_ready,
    output load_ready, out_valid, out_data, out_lane, out_last
  );

  modport slave (
    output sum_flat, load_valid, out_ready,
    input  load_ready, out_valid, out_data, out_lane, out_last
  );
endinterface

// File: rtl/multi_sum_serializer.sv
// Snapshots CNT lane sums on a load handshake and replays them one lane per beat,
// tagged with the lane index; a load on the final beat chains frames with no bubble.
module multi_sum_serializer #(
  parameter int unsigned N   = 12,
  parameter int unsigned CNT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_sum_serializer_if.master bus,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);
  localparam int unsigned W  = N + 1;
  localparam int unsigned LW = (CNT > 1) ? $clog2(CNT) : 1;
  localparam logic [LW-1:0] LastLane = LW'(CNT - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e           state_q;
  logic [CNT*W-1:0] snap_q;
  logic [LW-1:0]    lane_q;
  logic [W-1:0]     data_q;
  logic             last_q;
  logic [15:0]      frame_cnt_q;

  logic             send;
  logic             beat;
  logic             load;
  logic [LW-1:0]    lane_nxt;

  assign send     = (state_q == StSend);
  assign beat     = send & bus.out_ready;
  // Ready also on the last accepted beat so the next frame follows without a gap.
  assign bus.load_ready = ~send | (last_q & bus.out_ready);
  assign load     = bus.load_valid & bus.load_ready;
  assign lane_nxt = lane_q + LW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      snap_q      <= '0;
      lane_q      <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (beat && last_q) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (load) begin
        state_q <= StSend;
        snap_q  <= bus.sum_flat;
        lane_q  <= '0;
        data_q  <= bus.sum_flat[W-1:0];
        last_q  <= (CNT == 1);
      end else if (beat) begin
        if (last_q) begin
          state_q <= StIdle;
          last_q  <= 1'b0;
        end else begin
          lane_q <= lane_nxt;
          data_q <= snap_q[int'(lane_nxt) * W +: W];
          last_q <= (lane_nxt == LastLane);
        end
      end
    end
  end

  assign bus.out_valid = send;
  assign bus.out_data  = data_q;
  assign bus.out_lane  = lane_q;
  assign bus.out_last  = last_q;
  assign busy          = send;
  assign frame_cnt     = frame_cnt_q;
endmodule

// File: tb/tb_multi_sum_serializer.sv
// Directed bench: a per-cycle vector table for reset/single-frame/backpressure, then
// hand-written sequences for chaining, mid-frame reset, counter wrap and the one-lane case.
module tb_multi_sum_serializer;
  localparam int N   = 12;
  localparam int CNT = 8;
  localparam int W   = N + 1;
  localparam int LW  = 3;
  localparam int SW  = CNT * W;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy, busy1;
  logic [15:0] frame_cnt, frame_cnt1;

  multi_sum_serializer_if #(.N(N), .CNT(CNT)) bus ();
  multi_sum_serializer_if #(.N(N), .CNT(1))   bus1 ();

  multi_sum_serializer #(.N(N), .CNT(CNT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .frame_cnt(frame_cnt)
  );

  multi_sum_serializer #(.N(N), .CNT(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus1),
    .busy     (busy1),
    .frame_cnt(frame_cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, lv, ordy;
    logic [SW-1:0] sum;
    logic          chk;
    logic          e_valid, e_ready, e_busy, e_last;
    logic [W-1:0]  e_data;
    logic [LW-1:0] e_lane;
    logic [15:0]   e_fcnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] ramp(input int base);
    logic [SW-1:0] r;
    for (int i = 0; i < CNT; i++) r[i*W +: W] = W'(base + i);
    return r;
  endfunction

  task automatic add(input int r, input int lv, input int ordy, input logic [SW-1:0] sum,
                     input int c, input int ev, input int er, input int eb, input int el,
                     input int ed, input int elane, input int ef);
    vec_t v;
    v.rst = 1'(r);  v.lv = 1'(lv);  v.ordy = 1'(ordy);  v.sum = sum;  v.chk = 1'(c);
    v.e_valid = 1'(ev);  v.e_ready = 1'(er);  v.e_busy = 1'(eb);  v.e_last = 1'(el);
    v.e_data = W'(ed);  v.e_lane = LW'(elane);  v.e_fcnt = 16'(ef);
    tbl.push_back(v);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] all_b;
  int            exp_fcnt;

  initial begin
    rst = 1'b1;
    bus.load_valid = 1'b0;  bus.out_ready = 1'b1;  bus.sum_flat = '0;
    bus1.load_valid = 1'b0; bus1.out_ready = 1'b1; bus1.sum_flat = '0;
    for (int i = 0; i < CNT; i++) all_b[i*W +: W] = 13'h1FFF;

    // Reset held with load_valid high, then single frame with data scrubbed after load.
    add(1, 1, 1, ramp(100), 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, ramp(100), 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, ramp(100), 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, ramp(100), 1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) add(0, 0, 1, '0, 1, 1, int'(k == 7), 1, int'(k == 7), 100 + k, k, 0);
    // Idle again; reload and stall on lane 2 for three cycles.
    add(0, 1, 1, ramp(100), 1, 0, 1, 0, 0, 0, 0, 1);
    for (int k = 0; k < 2; k++) add(0, 0, 1, '0, 1, 1, 0, 1, 0, 100 + k, k, 1);
    for (int r = 0; r < 3; r++) add(0, 0, 0, '0, 1, 1, 0, 1, 0, 102, 2, 1);
    add(0, 0, 1, '0, 1, 1, 0, 1, 0, 102, 2, 1);
    for (int k = 3; k < 8; k++) add(0, 0, 1, '0, 1, 1, int'(k == 7), 1, int'(k == 7), 100 + k, k, 1);
    add(0, 0, 1, '0, 1, 0, 1, 0, 0, 0, 0, 2);

    cycle();
    foreach (tbl[i]) begin
      rst = tbl[i].rst;  bus.load_valid = tbl[i].lv;
      bus.out_ready = tbl[i].ordy;  bus.sum_flat = tbl[i].sum;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_valid));
        chk($sformatf("v%0d_ready", i), 32'(bus.load_ready), 32'(tbl[i].e_ready));
        chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
        chk($sformatf("v%0d_fcnt", i), 32'(frame_cnt), 32'(tbl[i].e_fcnt));
        if (tbl[i].e_valid) begin
          chk($sformatf("v%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_data));
          chk($sformatf("v%0d_lane", i), 32'(bus.out_lane), 32'(tbl[i].e_lane));
          chk($sformatf("v%0d_last", i), 32'(bus.out_last), 32'(tbl[i].e_last));
        end
      end
      cycle();
    end

    // Back-to-back: frame B held pending while A sends, taken on A's last beat.
    exp_fcnt = 2;
    bus.sum_flat = ramp(100);  bus.load_valid = 1'b1;  bus.out_ready = 1'b1;
    cycle();
    bus.sum_flat = all_b;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(bus.out_valid), 1);
      chk("b2b_data", 32'(bus.out_data), (k < 8) ? 100 + k : 32'h1FFF);
      chk("b2b_lane", 32'(bus.out_lane), k % 8);
      if (k < 8) chk("b2b_ready", 32'(bus.load_ready), 32'(k == 7));
      cycle();
      if (k == 7) bus.load_valid = 1'b0;
    end
    exp_fcnt += 2;
    @(negedge clk);
    chk("b2b_idle", 32'(bus.out_valid), 0);
    chk("b2b_fcnt", 32'(frame_cnt), exp_fcnt);
    cycle();

    // Reset while lane 4 is on the bus, with a handshake attempted in the same cycle.
    bus.sum_flat = ramp(100);  bus.load_valid = 1'b1;
    cycle();
    bus.load_valid = 1'b0;  bus.sum_flat = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("pre_rst_lane", 32'(bus.out_lane), k);
      if (k < 4) cycle();
    end
    rst = 1'b1;  bus.load_valid = 1'b1;
    cycle();
    rst = 1'b0;  bus.load_valid = 1'b0;
    exp_fcnt = 0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(bus.out_valid), 0);
    chk("rst_mid_lane", 32'(bus.out_lane), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_fcnt", 32'(frame_cnt), exp_fcnt);
    chk("rst_mid_ready", 32'(bus.load_ready), 1);
    cycle();
    bus.sum_flat = ramp(200);  bus.load_valid = 1'b1;
    cycle();
    bus.load_valid = 1'b0;  bus.sum_flat = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("restart_data", 32'(bus.out_data), 200 + k);
      chk("restart_lane", 32'(bus.out_lane), k);
      cycle();
    end
    @(negedge clk);
    chk("restart_fcnt", 32'(frame_cnt), 1);
    cycle();

    // Frame counter wraps from 0xFFFF.
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    @(negedge clk);
    chk("wrap_pre", 32'(frame_cnt), 32'hFFFF);
    cycle();
    bus.sum_flat = ramp(100);  bus.load_valid = 1'b1;
    cycle();
    bus.load_valid = 1'b0;
    repeat (8) cycle();
    @(negedge clk);
    chk("wrap_post", 32'(frame_cnt), 0);
    chk("wrap_idle", 32'(bus.out_valid), 0);
    cycle();

    // One lane: every beat is last, chained loads give one frame per cycle.
    bus1.load_valid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus1.sum_flat = 13'(10 + c);
      if (c == 5) bus1.load_valid = 1'b0;
      @(negedge clk);
      chk("c1_valid", 32'(bus1.out_valid), 32'(c >= 1 && c <= 5));
      chk("c1_ready", 32'(bus1.load_ready), 1);
      if (c >= 1 && c <= 5) begin
        chk("c1_data", 32'(bus1.out_data), 10 + c - 1);
        chk("c1_last", 32'(bus1.out_last), 1);
        chk("c1_lane", 32'(bus1.out_lane), 0);
      end
      cycle();
    end
    @(negedge clk);
    chk("c1_fcnt", 32'(frame_cnt1), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
